// File: rtl/sdram_arb_pkg.sv
// Shared command encodings, request-word field offsets and the packed request word
// for the SDRAM request arbiter.
package sdram_arb_pkg;

   localparam logic [1:0] CMD_REFRESH = 2'b00;
   localparam logic [1:0] CMD_READ    = 2'b01;
   localparam logic [1:0] CMD_WRITE   = 2'b10;

   localparam int LH_BIT   = 35;
   localparam int CMD_MSB  = 34;
   localparam int ADDR_MSB = 32;
   localparam int ADDR_LSB = 8;

   typedef struct packed {
      logic        lh;
      logic [1:0]  cmd;
      logic [24:0] addr;
      logic [7:0]  data;
   } rq_word_t;

endpackage

// File: rtl/sdram_tag_fifo.sv
// Small synchronous FIFO of port tags for outstanding reads; show-ahead output,
// simultaneous push/pop allowed even when full.
module sdram_tag_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 2
) (
   input  logic         sysclk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem;
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic [AW:0]             count;
   logic                    do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // a full FIFO can only take a push when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge sysclk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller FIFO pair among NUM_PORTS requesters.
// Define SDRAM_ARB_REFRESH_EN to build in the periodic auto-refresh timer/debt logic.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS        = 3,
   parameter int REFRESH_INTERVAL = 780,
   parameter int REFRESH_URGENT   = 4,
   parameter int TAG_DEPTH        = 8
) (
   input  logic                       sysclk,
   input  logic                       reset,
   input  logic [NUM_PORTS-1:0]       port_req,
   input  logic [NUM_PORTS-1:0]       port_we,
   input  logic [NUM_PORTS-1:0]       port_lh,
   input  logic [NUM_PORTS-1:0][24:0] port_addr,
   input  logic [NUM_PORTS-1:0][7:0]  port_wdata,
   output logic [NUM_PORTS-1:0]       port_ack,
   output logic [NUM_PORTS-1:0]       port_rvalid,
   output logic [7:0]                 port_rdata,
   input  logic                       rq_fifo_full,
   output logic                       rq_fifo_wrreq,
   output logic [35:0]                rq_fifo_data,
   input  logic                       an_fifo_empty,
   output logic                       an_fifo_rdreq,
   input  logic [8:0]                 an_fifo_q
);

   localparam int TAG_W = $clog2(NUM_PORTS);

   logic [TAG_W-1:0]     rr_ptr, rr_next, gnt_idx, cand, tag_q;
   logic [NUM_PORTS-1:0] eligible, rv_next;
   logic                 gnt_found, urgent, slot_ok, take, ref_issue;
   logic                 tag_full, tag_empty, tag_push, tag_pop, tag_can_push;
   logic                 sel_we, sel_lh;
   logic [24:0]          sel_addr;
   logic [7:0]           sel_wdata;
   logic [2:0]           debt;
   rq_word_t             word;
   logic                 unused_an_lh;

   assign unused_an_lh  = an_fifo_q[8];
   assign an_fifo_rdreq = !reset && !an_fifo_empty;
   assign tag_pop       = an_fifo_rdreq && !tag_empty;
   assign tag_can_push  = !tag_full || tag_pop;

   always_comb begin
      eligible  = port_req & (port_we | {NUM_PORTS{tag_can_push}});
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand = TAG_W'((int'(rr_ptr) + k) % NUM_PORTS);
         if (!gnt_found && eligible[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end

      urgent    = (debt >= 3'(REFRESH_URGENT));
      slot_ok   = !reset && !rq_fifo_full;
      ref_issue = slot_ok && (urgent || (debt != '0 && !gnt_found));
      take      = slot_ok && !urgent && gnt_found;

      port_ack  = '0;
      sel_we    = 1'b0;
      sel_lh    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (gnt_idx == TAG_W'(i)) begin
            sel_we      = port_we[i];
            sel_lh      = port_lh[i];
            sel_addr    = port_addr[i];
            sel_wdata   = port_wdata[i];
            port_ack[i] = take;
         end
      end

      // all-zero word is exactly the refresh command
      word = '0;
      if (take) begin
         word.lh   = sel_lh;
         word.cmd  = sel_we ? CMD_WRITE : CMD_READ;
         word.addr = sel_addr;
         word.data = sel_we ? sel_wdata : 8'h00;
      end
      tag_push = take && !sel_we;

      rv_next = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         rv_next[i] = tag_pop && (tag_q == TAG_W'(i));

      rr_next = (gnt_idx == TAG_W'(NUM_PORTS-1)) ? '0 : gnt_idx + TAG_W'(1);
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         rr_ptr        <= '0;
         rq_fifo_wrreq <= 1'b0;
         rq_fifo_data  <= '0;
         port_rvalid   <= '0;
         port_rdata    <= '0;
      end else begin
         rq_fifo_wrreq <= take || ref_issue;
         if (take || ref_issue) rq_fifo_data <= word;
         if (take) rr_ptr <= rr_next;
         port_rvalid <= rv_next;
         // orphan answers are popped but never touch rdata
         if (tag_pop) port_rdata <= an_fifo_q[7:0];
      end
   end

`ifdef SDRAM_ARB_REFRESH_EN
   localparam int TMR_W = $clog2(REFRESH_INTERVAL);
   logic [TMR_W-1:0] ref_timer;
   logic             ref_expire;

   assign ref_expire = (ref_timer == '0);

   always_ff @(posedge sysclk) begin
      if (reset) begin
         ref_timer <= TMR_W'(REFRESH_INTERVAL-1);
         debt      <= '0;
      end else begin
         ref_timer <= ref_expire ? TMR_W'(REFRESH_INTERVAL-1) : ref_timer - TMR_W'(1);
         if (ref_expire && !ref_issue && debt != 3'd7)
            debt <= debt + 3'd1;
         else if (!ref_expire && ref_issue)
            debt <= debt - 3'd1;
      end
   end
`else
   logic [31:0] unused_refresh_cfg;
   assign unused_refresh_cfg = REFRESH_INTERVAL;
   assign debt = '0;
`endif

   sdram_tag_fifo #(.DEPTH(TAG_DEPTH), .W(TAG_W)) u_tag_fifo (
      .sysclk (sysclk),
      .reset  (reset),
      .push   (tag_push),
      .pop    (tag_pop),
      .din    (gnt_idx),
      .dout   (tag_q),
      .full   (tag_full),
      .empty  (tag_empty)
   );

endmodule
